// File: rtl/chase_segment_decoder_pkg.sv
// Shared definitions for the chase segment decoder.
// Holds segment indices, the chase position -> segment table, the tracker
// state encoding and the segment -> position helper used by the tracker.
package chase_segment_decoder_pkg;

  localparam int DEF_WINDOW_LOG2 = 4;
  localparam int LEVEL_W         = DEF_WINDOW_LOG2 + 1;

  localparam logic [2:0] SEG_A = 3'd0;
  localparam logic [2:0] SEG_B = 3'd1;
  localparam logic [2:0] SEG_C = 3'd2;
  localparam logic [2:0] SEG_D = 3'd3;
  localparam logic [2:0] SEG_E = 3'd4;
  localparam logic [2:0] SEG_F = 3'd5;
  localparam logic [2:0] SEG_G = 3'd6;

  // Chase order, indexed by position: a, b, g, e, d, c, g, f
  localparam logic [7:0][2:0] POS_TO_SEG =
    {SEG_F, SEG_G, SEG_C, SEG_D, SEG_E, SEG_G, SEG_B, SEG_A};

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } trk_state_e;

  // Segment g appears twice in the chase (positions 2 and 6). It resolves
  // to 6 only when already locked in the upper half of the loop (5..7);
  // otherwise the lowest matching position (2) wins.
  function automatic logic [2:0] seg_to_pos(input logic [2:0] seg,
                                            input logic [2:0] cur_pos,
                                            input logic       is_locked);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (POS_TO_SEG[i] == seg) p = 3'(i);
    end
    if (seg == SEG_G && is_locked && cur_pos >= 3'd5) p = 3'd6;
    return p;
  endfunction

endpackage

// File: rtl/chase_segment_decoder_if.sv
// Bus bundle for the chase segment decoder.
// slave  : decoder side (receives seg_in/invert, drives measurements)
// master : driver/monitor side (drives seg_in/invert, reads measurements)
// level packs seven LVL_W-bit counts, segment i at slice i.
interface chase_segment_decoder_if
  import chase_segment_decoder_pkg::*;
#(
  parameter int LVL_W = LEVEL_W,
  parameter int PER_W = 12
);
  logic [6:0]         seg_in;
  logic               invert;
  logic [7*LVL_W-1:0] level;
  logic               frame_valid;
  logic               locked;
  logic [2:0]         pos;
  logic               dir;
  logic               step_valid;
  logic               lock_err;
  logic [PER_W-1:0]   period;

  modport slave (
    input  seg_in, invert,
    output level, frame_valid, locked, pos, dir, step_valid, lock_err, period
  );

  modport master (
    output seg_in, invert,
    input  level, frame_valid, locked, pos, dir, step_valid, lock_err, period
  );
endinterface

// File: rtl/chase_segment_decoder_meter.sv
// seg_pwm_meter: counts high samples of one segment over a measurement
// window and publishes the count when the window closes.
// Ports: clk, reset (sync, active-high), en (sample valid this cycle),
//        last (final sample of the window), sample, level (published count).
module seg_pwm_meter
  import chase_segment_decoder_pkg::*;
#(
  parameter int LVL_W = LEVEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             last,
  input  logic             sample,
  output logic [LVL_W-1:0] level
);
  // At most 2^N-1 samples are accumulated before the closing one, so the
  // accumulator needs one bit less than the published level.
  logic [LVL_W-2:0] acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      level <= '0;
    end else if (en) begin
      if (last) begin
        level <= {1'b0, acc} + LVL_W'(sample);
        acc   <= '0;
      end else begin
        acc <= acc + (LVL_W-1)'(sample);
      end
    end
  end
endmodule

// File: rtl/chase_segment_decoder.sv
// chase_segment_decoder: receive side of the 7-segment PWM chaser.
// Measures per-segment duty over a 2^WINDOW_LOG2-cycle window, picks the
// brightest segment as the chase head, maps it to a chase position and
// tracks direction and step period.
// Ports: clk, reset (sync, active-high), bus (slave modport):
//   seg_in/invert in; level, frame_valid, locked, pos, dir, step_valid,
//   lock_err, period out.
module chase_segment_decoder
  import chase_segment_decoder_pkg::*;
#(
  parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2,
  parameter int THRESH      = 4,
  parameter int LOSS_FRAMES = 4,
  parameter int PERIOD_W    = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  chase_segment_decoder_if.slave  bus
);
  localparam int LVL_W  = WINDOW_LOG2 + 1;
  localparam int LOSS_W = $clog2(LOSS_FRAMES + 1);

  logic [6:0]             sample_q;
  logic                   sample_vld;
  logic [WINDOW_LOG2-1:0] wcnt;
  logic                   win_last;
  logic                   frame_valid_q;
  logic [LVL_W-1:0]       lvl [7];

  trk_state_e             state;
  logic                   locked_q;
  logic [2:0]             pos_q;
  logic                   dir_q;
  logic                   step_valid_q;
  logic                   lock_err_q;
  logic [PERIOD_W-1:0]    period_q;
  logic [PERIOD_W-1:0]    frame_cnt;
  logic [LOSS_W-1:0]      loss_cnt;

  logic [LVL_W-1:0]       best_lvl;
  logic [2:0]             best_seg;
  logic                   head_ok;
  logic [2:0]             new_pos;
  logic [PERIOD_W-1:0]    period_next;
  logic [PERIOD_W-1:0]    frame_cnt_inc;

  // sample_vld keeps the reset value of sample_q out of the first window.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q      <= '0;
      sample_vld    <= 1'b0;
      wcnt          <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      sample_q      <= bus.seg_in ^ {7{bus.invert}};
      sample_vld    <= 1'b1;
      frame_valid_q <= win_last;
      if (sample_vld) wcnt <= wcnt + 1'b1;
    end
  end

  assign win_last = sample_vld && (wcnt == '1);

  for (genvar g = 0; g < 7; g++) begin : g_meter
    seg_pwm_meter #(.LVL_W(LVL_W)) u_meter (
      .clk    (clk),
      .reset  (reset),
      .en     (sample_vld),
      .last   (win_last),
      .sample (sample_q[g]),
      .level  (lvl[g])
    );
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    best_lvl = lvl[0];
    best_seg = 3'd0;
    for (int i = 1; i < 7; i++) begin
      if (lvl[i] > best_lvl) begin
        best_lvl = lvl[i];
        best_seg = 3'(i);
      end
    end
    head_ok = (best_lvl >= LVL_W'(THRESH));
    new_pos = seg_to_pos(best_seg, pos_q, state == LOCKED);
  end

  assign frame_cnt_inc = (frame_cnt == '1) ? frame_cnt : frame_cnt + 1'b1;
  assign period_next   = frame_cnt_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= UNLOCKED;
      locked_q     <= 1'b0;
      pos_q        <= '0;
      dir_q        <= 1'b0;
      step_valid_q <= 1'b0;
      lock_err_q   <= 1'b0;
      period_q     <= '0;
      frame_cnt    <= '0;
      loss_cnt     <= '0;
    end else begin
      step_valid_q <= 1'b0;
      lock_err_q   <= 1'b0;
      if (frame_valid_q) begin
        frame_cnt <= frame_cnt_inc;
        case (state)
          UNLOCKED: begin
            if (head_ok) begin
              state     <= LOCKED;
              locked_q  <= 1'b1;
              pos_q     <= new_pos;
              loss_cnt  <= '0;
              frame_cnt <= '0;
            end
          end
          LOCKED: begin
            if (head_ok) begin
              loss_cnt <= '0;
              if (new_pos != pos_q) begin
                pos_q     <= new_pos;
                frame_cnt <= '0;
                if (new_pos == pos_q + 3'd1) begin
                  dir_q        <= 1'b1;
                  step_valid_q <= 1'b1;
                  period_q     <= period_next;
                end else if (new_pos == pos_q - 3'd1) begin
                  dir_q        <= 1'b0;
                  step_valid_q <= 1'b1;
                  period_q     <= period_next;
                end else begin
                  lock_err_q <= 1'b1;
                end
              end
            end else if (loss_cnt == LOSS_W'(LOSS_FRAMES - 1)) begin
              state    <= UNLOCKED;
              locked_q <= 1'b0;
              loss_cnt <= '0;
            end else begin
              loss_cnt <= loss_cnt + 1'b1;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

  always_comb begin
    bus.level = '0;
    for (int i = 0; i < 7; i++) begin
      bus.level[i*LVL_W +: LVL_W] = lvl[i];
    end
  end

  assign bus.frame_valid = frame_valid_q;
  assign bus.locked      = locked_q;
  assign bus.pos         = pos_q;
  assign bus.dir         = dir_q;
  assign bus.step_valid  = step_valid_q;
  assign bus.lock_err    = lock_err_q;
  assign bus.period      = period_q;

endmodule

// File: tb/tb_chase_segment_decoder.sv
// Directed bench for chase_segment_decoder. Segment patterns are driven in
// 16-cycle frames aligned to the decoder window, so each frame's levels and
// tracker response are known exactly.
module tb_chase_segment_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inv = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  chase_segment_decoder_if #(.LVL_W(5), .PER_W(12)) bus ();

  chase_segment_decoder #(
    .WINDOW_LOG2 (4),
    .THRESH      (4),
    .LOSS_FRAMES (4),
    .PERIOD_W    (12)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  mask;
    logic [4:0]  duty;
    logic [2:0]  pos;
    logic        locked;
    logic        dir;
    logic        sv;
    logic        le;
    logic [11:0] period;
  } vec_t;

  vec_t vq[$];

  logic        snap_fv;
  logic [34:0] snap_level;
  logic        snap_locked;
  logic [2:0]  snap_pos;
  logic        snap_dir;
  logic        snap_sv;
  logic        snap_le;
  logic [11:0] snap_period;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.invert = inv;
    bus.seg_in = {7{inv}};
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"},  bus.level, 35'd0);
    check({tag, "_fv"},     bus.frame_valid, 1'b0);
    check({tag, "_locked"}, bus.locked, 1'b0);
    check({tag, "_pos"},    bus.pos, 3'd0);
    check({tag, "_dir"},    bus.dir, 1'b0);
    check({tag, "_sv"},     bus.step_valid, 1'b0);
    check({tag, "_le"},     bus.lock_err, 1'b0);
    check({tag, "_period"}, bus.period, 12'd0);
  endtask

  // Drives one aligned 16-cycle frame. The first two edges of this frame
  // publish the previous frame: level/frame_valid after edge 1, tracker
  // outputs after edge 2.
  task automatic run_frame(input logic [6:0] mask, input int duty);
    for (int p = 0; p < 16; p++) begin
      bus.seg_in = ((p < duty) ? mask : 7'h00) ^ {7{inv}};
      @(posedge clk);
      @(negedge clk);
      if (p == 0) begin
        snap_fv    = bus.frame_valid;
        snap_level = bus.level;
      end
      if (p == 1) begin
        snap_locked = bus.locked;
        snap_pos    = bus.pos;
        snap_dir    = bus.dir;
        snap_sv     = bus.step_valid;
        snap_le     = bus.lock_err;
        snap_period = bus.period;
      end
    end
  endtask

  task automatic add(input logic [6:0] mask, input int duty, input int pos,
                     input bit lk, input bit dir, input bit sv, input bit le,
                     input int period);
    vec_t v;
    v.mask   = mask;
    v.duty   = 5'(duty);
    v.pos    = 3'(pos);
    v.locked = lk;
    v.dir    = dir;
    v.sv     = sv;
    v.le     = le;
    v.period = 12'(period);
    vq.push_back(v);
  endtask

  task automatic check_frame(input int scen, input int idx, input vec_t v);
    logic [34:0] el;
    string t;
    el = '0;
    for (int s = 0; s < 7; s++) el[s*5 +: 5] = v.mask[s] ? v.duty : 5'd0;
    t = $sformatf("s%0d_f%0d", scen, idx);
    check({t, "_fv"},     snap_fv, 1'b1);
    check({t, "_level"},  snap_level, el);
    check({t, "_locked"}, snap_locked, v.locked);
    check({t, "_pos"},    snap_pos, v.pos);
    check({t, "_dir"},    snap_dir, v.dir);
    check({t, "_sv"},     snap_sv, v.sv);
    check({t, "_le"},     snap_le, v.le);
    check({t, "_period"}, snap_period, v.period);
  endtask

  // Runs the queued frames plus one idle frame to collect the last result.
  task automatic run_seq(input int scen);
    for (int i = 0; i <= vq.size(); i++) begin
      if (i < vq.size()) run_frame(vq[i].mask, int'(vq[i].duty));
      else               run_frame(7'h00, 0);
      if (i > 0) check_frame(scen, i - 1, vq[i-1]);
    end
    vq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_fv;
    bus.seg_in = 7'h00;
    bus.invert = 1'b0;

    // 1: idle lines, frame_valid cadence after reset
    inv = 1'b0;
    do_reset();
    check_reset_state("rst1");
    release_reset();
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("s1_fv_c%0d", c), bus.frame_valid, (c == 17 || c == 33));
    end
    check("s1_level", bus.level, 35'd0);
    check("s1_locked", bus.locked, 1'b0);

    // 2: segment a fully on locks at position 0
    do_reset();
    release_reset();
    add(7'h01, 16, 0, 1, 0, 0, 0, 0);
    add(7'h01, 16, 0, 1, 0, 0, 0, 0);
    run_seq(2);

    // 3: incrementing chase a,b,g,e at 7/16, then jump and wrap cases
    do_reset();
    release_reset();
    for (int k = 0; k < 4; k++) add(7'h01, 7, 0, 1, 0, 0, 0, 0);
    add(7'h02, 7, 1, 1, 1, 1, 0, 4);
    for (int k = 0; k < 3; k++) add(7'h02, 7, 1, 1, 1, 0, 0, 4);
    add(7'h40, 7, 2, 1, 1, 1, 0, 4);
    for (int k = 0; k < 3; k++) add(7'h40, 7, 2, 1, 1, 0, 0, 4);
    add(7'h10, 7, 3, 1, 1, 1, 0, 4);
    add(7'h01, 7, 0, 1, 1, 0, 1, 4);
    add(7'h20, 7, 7, 1, 0, 1, 0, 1);
    add(7'h01, 7, 0, 1, 1, 1, 0, 1);
    run_seq(3);

    // 4: decrementing a -> f -> g(6) -> c
    do_reset();
    release_reset();
    add(7'h01, 16, 0, 1, 0, 0, 0, 0);
    add(7'h01, 16, 0, 1, 0, 0, 0, 0);
    add(7'h20, 16, 7, 1, 0, 1, 0, 2);
    add(7'h20, 16, 7, 1, 0, 0, 0, 2);
    add(7'h40, 16, 6, 1, 0, 1, 0, 2);
    add(7'h40, 16, 6, 1, 0, 0, 0, 2);
    add(7'h04, 16, 5, 1, 0, 1, 0, 2);
    run_seq(4);

    // 5: lock error, loss of lock, threshold edge, tie-breaks
    do_reset();
    release_reset();
    add(7'h01, 16, 0, 1, 0, 0, 0, 0);
    add(7'h08, 16, 4, 1, 0, 0, 1, 0);
    add(7'h00, 0,  4, 1, 0, 0, 0, 0);
    add(7'h00, 0,  4, 1, 0, 0, 0, 0);
    add(7'h00, 0,  4, 1, 0, 0, 0, 0);
    add(7'h00, 0,  4, 0, 0, 0, 0, 0);
    add(7'h01, 3,  4, 0, 0, 0, 0, 0);
    add(7'h02, 4,  1, 1, 0, 0, 0, 0);
    add(7'h22, 10, 1, 1, 0, 0, 0, 0);
    add(7'h44, 9,  5, 1, 0, 0, 1, 0);
    run_seq(5);

    // 6: inverted polarity, then reset in mid-window
    inv = 1'b1;
    do_reset();
    check_reset_state("rst6a");
    release_reset();
    add(7'h01, 16, 0, 1, 0, 0, 0, 0);
    run_seq(6);
    for (int p = 0; p < 9; p++) begin
      bus.seg_in = 7'h7E;
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("rst6b");
    reset = 1'b0;
    bus.seg_in = 7'h7F;
    first_fv = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.frame_valid && first_fv == 0) first_fv = c;
    end
    check("s6_fv_after_reset", 64'(first_fv), 64'd17);
    check("s6_level_after_reset", bus.level, 35'd0);
    check("s6_locked_after_reset", bus.locked, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chase_segment_decoder.md
Name: chase_segment_decoder

Overview:
- Receive-side counterpart of the 7-segment PWM chaser: samples the seven PWM-faded segment lines and recovers per-segment brightness.
- Identifies the lit "head" segment, maps it back to the 3-bit chase position, and infers chase direction and step period.
- Used as an on-chip loop-back checker and a bench monitor.
- Chase order (position -> segment): 0->a(0), 1->b(1), 2->g(6), 3->e(4), 4->d(3), 5->c(2), 6->g(6), 7->f(5).

Parameters:
- WINDOW_LOG2, 4, log2 of PWM measurement window in clk cycles (window = 16).
- THRESH, 4, minimum level for a head to count as valid.
- LOSS_FRAMES, 4, consecutive frames without a valid head before lock is dropped.
- PERIOD_W, 12, width of step-period counter, in frames.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- seg_in  in  7  raw segment lines, bit i = segment i
- invert  in  1  polarity select; sample = seg_in ^ {7{invert}}
- level  out  7*(WINDOW_LOG2+1)  per-segment high-sample count for the last window, segment i at slice i
- frame_valid  out  1  one-cycle pulse when level updates
- locked  out  1  tracker has a valid position
- pos  out  3  decoded chase position
- dir  out  1  1 = incrementing, 0 = decrementing
- step_valid  out  1  one-cycle pulse on a legal single step
- lock_err  out  1  one-cycle pulse on a non-adjacent jump while locked
- period  out  PERIOD_W  frames between the last two legal steps

Behaviour:
- Input stage: seg_in XOR invert is registered once (1 cycle) before counting.
- Window counter wcnt runs 0..2^WINDOW_LOG2-1 and wraps freely.
- Per-segment accumulators count high samples. On wcnt == max:
  - level is loaded with accumulator + that cycle's sample (range 0..16, 5 bits, no saturation).
  - Accumulators clear.
  - frame_valid is asserted the same clock edge, so it is high for the cycle following wcnt == max.
- Head select: segment with the highest level; ties go to the lowest index. Head is valid iff max level >= THRESH.
- Segment -> position map: 0->0, 1->1, 4->3, 3->4, 2->5, 5->7.
  - Segment 6 resolves to 2 if the current pos is in {1,2,3}, and to 6 if pos is in {5,6,7}.
  - Segment 6 resolves to 2 when UNLOCKED or when pos is in {0,4}.
- Tracker FSM, evaluated on the cycle frame_valid is high. All outputs are registered and update 1 cycle after frame_valid.
  - UNLOCKED:
    - Valid head -> pos = map(head); go to LOCKED; loss counter = 0; no step_valid.
    - Otherwise stay UNLOCKED.
  - LOCKED, valid head:
    - Same pos -> no change.
    - new == pos+1 mod 8 -> dir = 1, step_valid.
    - new == pos-1 mod 8 -> dir = 0, step_valid.
    - Any other pos -> lock_err, pos = new, dir unchanged.
    - In all valid-head cases loss counter = 0.
  - LOCKED, invalid head: loss counter++. When it reaches LOSS_FRAMES -> UNLOCKED; pos and dir are held.
  - Wrap-around: 7 -> 0 is an increment; 0 -> 7 is a decrement.
- Period measurement:
  - frame counter increments each frame and saturates at all-ones.
  - On step_valid: period = frame counter + 1 (saturating), frame counter = 0.
  - On lock_err or on entry to LOCKED: frame counter = 0, period unchanged.
- Reset values: all accumulators, level, wcnt, pos, period and counters 0; frame_valid, step_valid, lock_err, locked, dir all 0; FSM UNLOCKED.
- Reset mid-window discards the partial window; the first frame_valid follows 2^WINDOW_LOG2+1 cycles after reset release (1 cycle for the input register).
- The invert input is not registered separately; a change takes effect from the next sample.

Decomposition:
- Shared package holds:
  - the position<->segment map constants;
  - segment index constants SEG_A..SEG_G;
  - the tracker state enum (UNLOCKED, LOCKED);
  - LEVEL_W = WINDOW_LOG2+1.
- Natural sub-module: seg_pwm_meter (one instance per segment), containing the accumulator plus level register and sharing wcnt from the parent.
- Head select, mapping, FSM and period counter stay in the top module.

Test Plan:
- Reset, seg_in = 0x00, invert = 0 for 40 cycles -> all level = 0; frame_valid pulses at cycle 17 and 33 after release; locked = 0.
- seg_in bit0 held high, others low -> level[0] = 16, others 0; locked = 1, pos = 0 one cycle after the first frame_valid; no step_valid.
- Drive the head 7/16 duty through segments a, b, g, e (one segment per 4 frames) -> step_valid x3, dir = 1, pos sequence 0, 1, 2, 3, period = 4.
- Decrement from pos 0 via segment f, then c from pos 7 (f, g, c order) -> dir = 0, pos 7 -> 6 (g resolved to 6) -> 5.
- Locked at pos 0, then segment d alone -> lock_err pulse, pos = 4, step_valid = 0; then all lines low for 4 frames -> locked = 0, pos held at 4.
- invert = 1 with seg_in = 0x7E (only segment a active-low) -> level[0] = 16, pos = 0; assert reset at wcnt = 8 -> all outputs 0, next frame_valid 17 cycles after release.
